// File: rtl/tp_mul_pipe_us.sv
// Pipelined unsigned x signed multiplier with shift, saturation, tag
// sideband and a valid/ready handshake that stalls the whole pipe.
module tp_mul_pipe_us #(
    parameter int A_W    = 16,
    parameter int B_W    = 16,
    parameter int P_W    = 30,
    parameter int STAGES = 3,
    parameter int SHIFT  = 0,
    parameter int SAT    = 1,
    parameter int TAG_W  = 8
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_W-1:0]   dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);

    localparam int FW = A_W + B_W + 1;
    localparam int XW = (FW > P_W) ? FW : P_W;
    localparam logic signed [XW-1:0] PMAX =
        {{(XW-P_W+1){1'b0}}, {(P_W-1){1'b1}}};
    localparam logic signed [XW-1:0] PMIN =
        {{(XW-P_W+1){1'b1}}, {(P_W-1){1'b0}}};

    logic                    w_adv;
    logic signed [FW-1:0]    w_full;
    logic signed [FW-1:0]    w_fin;
    logic signed [FW-1:0]    w_sh;
    logic signed [XW-1:0]    w_shx;
    logic                    w_fin_v;
    logic [TAG_W-1:0]        w_fin_tag;
    logic                    w_ovf;
    logic [P_W-1:0]          w_nar;

    logic                    r_out_v;
    logic [P_W-1:0]          r_dout;
    logic [TAG_W-1:0]        r_tag;
    logic                    r_ovf;

    assign w_adv    = ~r_out_v | out_ready;
    assign in_ready = w_adv;

    assign w_full = FW'($signed({1'b0, din0})) * FW'($signed(din1));

    generate
        if (STAGES == 1) begin : g_s1
            assign w_fin     = w_full;
            assign w_fin_v   = in_valid;
            assign w_fin_tag = in_tag;
        end else begin : g_sn
            for (genvar i = 0; i < STAGES - 1; i++) begin : g_st
                logic                 r_v;
                logic signed [FW-1:0] r_p;
                logic [TAG_W-1:0]     r_t;
                logic                 w_v_in;
                logic signed [FW-1:0] w_p_in;
                logic [TAG_W-1:0]     w_t_in;

                if (i == 0) begin : g_src
                    assign w_v_in = in_valid;
                    assign w_p_in = w_full;
                    assign w_t_in = in_tag;
                end else begin : g_src
                    assign w_v_in = g_st[i-1].r_v;
                    assign w_p_in = g_st[i-1].r_p;
                    assign w_t_in = g_st[i-1].r_t;
                end

                always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                    if (!ap_rst_n) begin
                        r_v <= 1'b0;
                        r_p <= '0;
                        r_t <= '0;
                    end else if (w_adv) begin
                        r_v <= w_v_in;
                        r_p <= w_p_in;
                        r_t <= w_t_in;
                    end
                end
            end
            assign w_fin     = g_st[STAGES-2].r_p;
            assign w_fin_v   = g_st[STAGES-2].r_v;
            assign w_fin_tag = g_st[STAGES-2].r_t;
        end
    endgenerate

    // Floor shift on the exact product, then range check in a width
    // wide enough to hold both the product and the result bounds.
    assign w_sh  = w_fin >>> SHIFT;
    assign w_shx = XW'(w_sh);
    assign w_ovf = (w_shx > PMAX) || (w_shx < PMIN);

    always_comb begin
        w_nar = w_shx[P_W-1:0];
        if (SAT != 0 && w_ovf) begin
            w_nar = w_shx[XW-1] ? PMIN[P_W-1:0] : PMAX[P_W-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_v <= 1'b0;
            r_dout  <= '0;
            r_tag   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_out_v <= w_fin_v;
            r_dout  <= w_nar;
            r_tag   <= w_fin_tag;
            r_ovf   <= w_ovf;
        end
    end

    assign out_valid = r_out_v;
    assign dout      = r_dout;
    assign out_tag   = r_tag;
    assign out_ovf   = r_ovf;

endmodule
